// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous instruction/data memory port between the multi-cycle
//   CPU and a debug/program-loader port. It uses a req/gnt handshake and allows
//   one outstanding read at a time. The CPU has fixed priority. After STARVE_MAX
//   consecutive refused cycles, the debug port wins arbitration instead.
//
//   Parameters: ADDR_W, DATA_W, RD_LAT (1..4, mem_en cycle to mem_rdata valid),
//               STARVE_MAX (1..15).
//   Ports:
//     CLK, Reset                 clock (rising edge), synchronous active-high reset
//     cpu_req/we/addr/wdata      CPU request       -> cpu_gnt, cpu_rvalid, cpu_rdata
//     dbg_req/we/addr/wdata      debug request     -> dbg_gnt, dbg_rvalid, dbg_rdata
//     mem_en/we/addr/wdata       memory request, driven combinationally in grant cycles
//     mem_rdata                  memory read data
//     busy                       a read is outstanding
//   Optional macro MEM_ARB_PERF_EN adds the 16-bit saturating counters
//     perf_cpu_grants, perf_dbg_grants and perf_conflicts.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_cpu_grants,
    output logic [15:0]       perf_dbg_grants,
    output logic [15:0]       perf_conflicts
`endif
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [2:0] LAT_END    = 3'(RD_LAT);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

    state_t            state;
    logic [2:0]        lat_cnt;
    logic [3:0]        starve_cnt;
    logic              owner_dbg;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic resp;
    logic can_grant;
    logic dbg_wins;

    // The response cycle is qualified by !Reset. A read that is in flight when
    // Reset arrives therefore never produces an rvalid.
    assign resp      = (state == RD_WAIT) && (lat_cnt == LAT_END) && !Reset;
    assign can_grant = !Reset && ((state == IDLE) || resp);
    assign dbg_wins  = dbg_req && (!cpu_req || (starve_cnt == STARVE_TOP));
    assign cpu_gnt   = can_grant && cpu_req && !dbg_wins;
    assign dbg_gnt   = can_grant && dbg_wins;
    assign mem_en    = cpu_gnt || dbg_gnt;
    assign busy      = (state == RD_WAIT);

    // Address and write data keep their last granted value outside grant cycles.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_rvalid = resp && !owner_dbg;
    assign dbg_rvalid = resp && owner_dbg;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            owner_dbg   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (dbg_gnt || !dbg_req)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_TOP)
                starve_cnt <= starve_cnt + 4'd1;

            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dbg_rvalid) dbg_rdata_q <= mem_rdata;

            // A read granted in the response cycle restarts the count at 1.
            if (mem_en && !mem_we) begin
                state     <= RD_WAIT;
                lat_cnt   <= 3'd1;
                owner_dbg <= dbg_gnt;
            end else if (resp) begin
                state   <= IDLE;
                lat_cnt <= '0;
            end else if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            perf_cpu_grants <= '0;
            perf_dbg_grants <= '0;
            perf_conflicts  <= '0;
        end else begin
            if (cpu_gnt && (perf_cpu_grants != '1))
                perf_cpu_grants <= perf_cpu_grants + 16'd1;
            if (dbg_gnt && (perf_dbg_grants != '1))
                perf_dbg_grants <= perf_dbg_grants + 16'd1;
            if (cpu_req && dbg_req && can_grant && (perf_conflicts != '1))
                perf_conflicts <= perf_conflicts + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between two requesters: the multi-cycle CPU (fetch, LW, SW) and a debug/program-loader port.
- Sits between the CPU datapath memory interface (IoD-muxed address) and the unified instruction/data memory.
- Uses a req/gnt handshake with one outstanding read at a time.
- Gives the CPU fixed priority, with an anti-starvation override for the debug port.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- RD_LAT, 1, memory read latency in cycles, from the mem_en cycle to mem_rdata valid; legal range 1..4.
- STARVE_MAX, 4, consecutive refused debug-request cycles after which debug wins arbitration; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same meaning as the CPU signals.
- dbg_gnt / dbg_rvalid / dbg_rdata  out  1/1/DATA_W  debug grant and response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  read outstanding.

Behaviour:
- Reset (synchronous, on the CLK edge with Reset=1):
  - State goes to IDLE; starve counter and latency counter clear to 0.
  - All gnt, rvalid, mem_en, mem_we and busy outputs are 0; rdata outputs are 0.
  - A read in flight when Reset is applied is dropped: no rvalid is ever issued for it.
- States:
  - IDLE: no read outstanding.
  - RD_WAIT: read outstanding; latency counter counts 1..RD_LAT.
- Arbitration:
  - Grants are issued only in IDLE, or in the RD_WAIT cycle where the counter equals RD_LAT (the response cycle).
  - Grant is combinational in the accept cycle.
  - Winner is the CPU if cpu_req=1, unless dbg_req=1 and starve_cnt==STARVE_MAX, in which case debug wins.
  - If only one requester is asserting req, that requester wins.
  - At most one gnt is high per cycle.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each cycle with dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt=1 or when dbg_req=0.
- Requester rules:
  - Requesters hold req, we, addr and wdata stable until gnt.
  - req may drop without a grant; the arbiter keeps no memory of a dropped request.
- Grant cycle T:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the winner, combinationally.
  - Outside grant cycles mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last value.
- Write: completes in cycle T, with no rvalid.
  - Back-to-back write grants every cycle are legal.
  - A write grant in IDLE leaves the state in IDLE; a write grant in the response cycle moves the state to IDLE.
- Read:
  - State goes to RD_WAIT at T+1 and busy=1 from T+1.
  - The owner is recorded.
  - At cycle T+RD_LAT the owner's rvalid=1 and its rdata=mem_rdata (combinational pass-through). rdata is registered-held after that cycle and updates only on the owner's next rvalid.
  - The non-owner's rvalid stays 0.
- Response cycle:
  - A new grant may coincide with it; a new read re-enters RD_WAIT with the counter reset to 1.
  - If there is no new grant, the state returns to IDLE and busy=0 at T+RD_LAT+1.
- RD_WAIT cycles other than the response cycle: all gnt=0 and requests stall.
- The CPU control FSM treats cpu_gnt=0 as a stall and holds its state; the FSM itself is unchanged.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, three extra outputs are added, each 16 bits, saturating at 0xFFFF and cleared by Reset:
  - perf_cpu_grants: counts cpu_gnt cycles.
  - perf_dbg_grants: counts dbg_gnt cycles.
  - perf_conflicts: counts cycles with cpu_req=1 and dbg_req=1 while a grant was possible.
- When undefined, these ports and their counters are absent, and all other behaviour is identical.

Test Plan:
- Reset, then CPU read addr 0x0010, RD_LAT=1, memory returns 0xBEEF: cpu_gnt at T, mem_en=1, mem_we=0, mem_addr=0x0010 at T; cpu_rvalid=1 with cpu_rdata=0xBEEF at T+1; busy=1 at T+1 only.
- CPU write 0x0020 <= 0x1234, then a CPU write the next cycle: two consecutive cpu_gnt and two consecutive mem_we=1; no rvalid.
- cpu_req and dbg_req both held high, STARVE_MAX=4, all CPU writes: CPU is granted 4 cycles; dbg_gnt in the 5th; starve_cnt then returns to 0.
- CPU read pending (RD_LAT=3) while dbg_req asserts at T+1: dbg_gnt=0 at T+1 and T+2; dbg_gnt=1 at T+3, coincident with cpu_rvalid=1.
- Reset asserted at T+1 of a debug read with RD_LAT=2: dbg_rvalid stays 0 throughout; all outputs are 0 the cycle after Reset.
- With MEM_ARB_PERF_EN: 3 CPU and 2 debug grants with 1 conflict cycle give perf counters 3, 2 and 1.
